i2c_txn_sequencer: RTL and testbench

//  Command front-end sitting directly upstream of I2C_master. Queues single-byte read/write

---
 rtl/i2c_txn_sequencer_pkg.sv | 33 +++
 rtl/i2c_txn_sequencer_cmd_fifo.sv | 62 ++++++
 rtl/i2c_txn_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_txn_sequencer_pkg.sv
`default_nettype none
// ==========================================================================
// i2c_txn_sequencer_pkg: shared command/response/state types for the sequencer.
// Revision: 1.0
// ==========================================================================
package i2c_txn_sequencer_pkg;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       next_byte;
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_NACK    = 2'b01,
    RSP_TIMEOUT = 2'b10
  } i2c_rsp_status_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHECK     = 3'd4,
    ST_RETRY_GAP = 3'd5,
    ST_RESP      = 3'd6,
    ST_GAP       = 3'd7
  } i2c_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_txn_sequencer_cmd_fifo.sv
`default_nettype none
// ==========================================================================
// i2c_txn_sequencer_cmd_fifo: synchronous command FIFO, power-of-2 depth.
// Revision: 1.0
// ==========================================================================
module i2c_txn_sequencer_cmd_fifo
  import i2c_txn_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  i2c_cmd_t                 i_din,
  input  logic                     i_pop,
  output i2c_cmd_t                 o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  i2c_cmd_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == c_depth);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
`default_nettype none
// ==========================================================================
// i2c_txn_sequencer: queues I2C byte commands, drives the master handshake, retries NACKs.
// Revision: 1.0
// ==========================================================================
module i2c_txn_sequencer
  import i2c_txn_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 8
) (
  input  logic                          i_clk_400,
  input  logic                          i_rst,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_rw,
  input  logic [6:0]                    i_cmd_addr,
  input  logic [7:0]                    i_cmd_wdata,
  input  logic                          i_cmd_next_byte,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [7:0]                    o_rsp_rdata,
  output logic [1:0]                    o_rsp_status,
  output logic                          o_m_start_txn,
  output logic                          o_m_rw,
  output logic [6:0]                    o_m_sub_addr,
  output logic [7:0]                    o_m_data_in,
  output logic                          o_m_next_byte,
  input  logic                          i_m_done,
  input  logic                          i_m_ack_error,
  input  logic [7:0]                    i_m_data_out,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] c_tmo_last  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] c_gap_last  = GW'(GAP_CYC - 1);
  localparam logic [RW-1:0] c_retry_max = RW'(MAX_RETRY);

  i2c_seq_state_t  r_state;
  i2c_seq_state_t  w_state_nxt;
  i2c_cmd_t        w_cmd_in;
  i2c_cmd_t        w_fifo_dout;
  i2c_cmd_t        r_cmd;
  i2c_rsp_status_t r_rsp_status;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_done_rise;
  logic            w_start;
  logic            w_rsp_valid;
  logic            r_done_q;
  logic            r_ack_err;
  logic [7:0]      r_rd_smp;
  logic [7:0]      r_rsp_rdata;
  logic [TW-1:0]   r_timer;
  logic [GW-1:0]   r_gap;
  logic [RW-1:0]   r_retry;

  assign w_cmd_in    = '{rw: i_cmd_rw, addr: i_cmd_addr, wdata: i_cmd_wdata,
                         next_byte: i_cmd_next_byte};
  assign o_cmd_ready = !w_full;
  assign w_push      = i_cmd_valid && !w_full;
  assign w_done_rise = i_m_done && !r_done_q;

  i2c_txn_sequencer_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (i_clk_400),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (w_cmd_in),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (o_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk_400) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // IDLE also leaves on an incoming push so the head is ready to pop in LOAD.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE:      if (!w_empty || w_push) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_pop       = 1'b1;
        w_state_nxt = ST_START;
      end
      ST_START: begin
        w_start     = 1'b1;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_done_rise)                w_state_nxt = ST_CHECK;
        else if (r_timer == c_tmo_last) w_state_nxt = ST_RESP;
      end
      ST_CHECK: begin
        if (r_ack_err && (r_retry != c_retry_max)) w_state_nxt = ST_RETRY_GAP;
        else                                       w_state_nxt = ST_RESP;
      end
      ST_RETRY_GAP: if (r_gap == c_gap_last) w_state_nxt = ST_START;
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_nxt = ST_GAP;
      end
      ST_GAP:       if (r_gap == c_gap_last) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_400) begin
    if (i_rst) begin
      r_done_q     <= 1'b0;
      r_cmd        <= '0;
      r_ack_err    <= 1'b0;
      r_rd_smp     <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= RSP_OK;
      r_timer      <= '0;
      r_gap        <= '0;
      r_retry      <= '0;
    end else begin
      r_done_q <= i_m_done;
      case (r_state)
        ST_LOAD: begin
          r_cmd   <= w_fifo_dout;
          r_retry <= '0;
        end
        ST_START: r_timer <= '0;
        ST_WAIT_DONE: begin
          r_timer <= r_timer + 1'b1;
          if (w_done_rise) begin
            r_ack_err <= i_m_ack_error;
            r_rd_smp  <= i_m_data_out;
          end else if (r_timer == c_tmo_last) begin
            r_rsp_status <= RSP_TIMEOUT;
            r_rsp_rdata  <= 8'h00;
          end
        end
        ST_CHECK: begin
          if (!r_ack_err) begin
            r_rsp_status <= RSP_OK;
            r_rsp_rdata  <= r_cmd.rw ? r_rd_smp : 8'h00;
          end else if (r_retry != c_retry_max) begin
            r_retry <= r_retry + 1'b1;
          end else begin
            r_rsp_status <= RSP_NACK;
            r_rsp_rdata  <= 8'h00;
          end
        end
        ST_RETRY_GAP, ST_GAP: r_gap <= (r_gap == c_gap_last) ? '0 : r_gap + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_rsp_valid   = w_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_status  = r_rsp_status;
  assign o_m_start_txn = w_start;
  assign o_m_rw        = r_cmd.rw;
  assign o_m_sub_addr  = r_cmd.addr;
  assign o_m_data_in   = r_cmd.wdata;
  assign o_m_next_byte = r_cmd.next_byte;
  assign o_busy        = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_i2c_txn_sequencer: directed bench with a stub master/subordinate at address 0x01.
// Revision: 1.0
// ==========================================================================
module tb_i2c_txn_sequencer;

  localparam int FIFO_DEPTH  = 4;
  localparam int MAX_RETRY   = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int GAP_CYC     = 8;
  localparam int STUB_DLY    = 5;
  // Start edge A: done seen at A+6, CHECK->RETRY_GAP at A+7, 8 gap cycles, next START at A+16.
  localparam int RETRY_SPACING = 16;
  // Start edge A: 64 WAIT_DONE cycles, RESP first sampled at A+65.
  localparam int TMO_RSP_LAT   = 65;
  localparam int START_LAT     = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rw, cmd_next_byte;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic       m_start_txn, m_rw, m_next_byte;
  logic [6:0] m_sub_addr;
  logic [7:0] m_data_in;
  logic       m_done, m_ack_error;
  logic [7:0] m_data_out;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_txn_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_RETRY  (MAX_RETRY),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .i_clk_400      (clk),
    .i_rst          (rst),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_rw       (cmd_rw),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_wdata    (cmd_wdata),
    .i_cmd_next_byte(cmd_next_byte),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_status   (rsp_status),
    .o_m_start_txn  (m_start_txn),
    .o_m_rw         (m_rw),
    .o_m_sub_addr   (m_sub_addr),
    .o_m_data_in    (m_data_in),
    .o_m_next_byte  (m_next_byte),
    .i_m_done       (m_done),
    .i_m_ack_error  (m_ack_error),
    .i_m_data_out   (m_data_out),
    .o_busy         (busy),
    .o_fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  // Event monitor: edge indices of start pulses, accepted pushes and response rises.
  int   cyc = 0, start_cnt = 0, last_start = 0, prev_start = 0, last_push = 0, rsp_rise = 0;
  logic rsp_q = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_start_txn) begin
      start_cnt  <= start_cnt + 1;
      prev_start <= last_start;
      last_start <= cyc;
    end
    if (cmd_valid && cmd_ready) last_push <= cyc;
    rsp_q <= rsp_valid;
    if (rsp_valid && !rsp_q) rsp_rise <= cyc;
  end

  // Stub master: done rises STUB_DLY edges after start; only address 0x01 ACKs.
  logic       stub_hang = 1'b0;
  int         stub_cnt  = 0;
  logic [7:0] stub_mem  = 8'h00;
  always @(posedge clk) begin
    if (rst) begin
      m_done   <= 1'b0;
      stub_cnt <= 0;
    end else if (m_start_txn) begin
      m_done   <= 1'b0;
      stub_cnt <= STUB_DLY;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_hang) begin
        m_done <= 1'b1;
        if (m_sub_addr == 7'h01) begin
          m_ack_error <= 1'b0;
          if (m_rw) m_data_out <= stub_mem;
          else begin
            m_data_out <= 8'hEE;
            stub_mem   <= m_data_in;
          end
        end else begin
          m_ack_error <= 1'b1;
          m_data_out  <= 8'hFF;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wd);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("push_ready", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input logic [7:0] exp_rdata, input logic [1:0] exp_status);
    int k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 1);
    if (rsp_valid) begin
      check({tag, "_status"}, {30'd0, rsp_status}, {30'd0, exp_status});
      check({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp_rdata});
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle", {31'd0, busy}, 0);
  endtask

  logic [7:0] fill_wd   [5] = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h33};
  logic       fill_rw   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] fill_exp  [5] = '{8'h00, 8'h11, 8'h00, 8'h22, 8'h00};

  initial begin
    int s0, k, bad;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_next_byte = 1'b0; rsp_ready = 1'b0; m_ack_error = 1'b0; m_data_out = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_start", {31'd0, m_start_txn}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_count", {29'd0, fifo_count}, 0);
    check("rst_status", {30'd0, rsp_status}, 0);
    check("rst_rdata", {24'd0, rsp_rdata}, 0);

    // Write 0xAB to 0x01
    s0 = start_cnt;
    push_cmd(1'b0, 7'h01, 8'hAB);
    get_rsp("wr", 8'h00, 2'b00);
    check("wr_starts", start_cnt - s0, 1);
    check("wr_latency", last_start - last_push, START_LAT);
    check("wr_sub_data", {24'd0, stub_mem}, 32'hAB);
    wait_idle();

    // Preload 0xC3 then read it back
    push_cmd(1'b0, 7'h01, 8'hC3);
    get_rsp("wr2", 8'h00, 2'b00);
    wait_idle();
    s0 = start_cnt;
    push_cmd(1'b1, 7'h01, 8'h00);
    get_rsp("rd", 8'hC3, 2'b00);
    check("rd_starts", start_cnt - s0, 1);
    check("rd_latency", last_start - last_push, START_LAT);
    wait_idle();

    // NACKed write: 1 + MAX_RETRY attempts
    s0 = start_cnt;
    push_cmd(1'b0, 7'h55, 8'h12);
    get_rsp("nack", 8'h00, 2'b01);
    check("nack_starts", start_cnt - s0, 3);
    check("nack_spacing", last_start - prev_start, RETRY_SPACING);
    check("nack_mem", {24'd0, stub_mem}, 32'hC3);
    wait_idle();

    // Master never finishes: timeout on a read, rdata forced to zero
    stub_hang = 1'b1;
    s0 = start_cnt;
    push_cmd(1'b1, 7'h01, 8'h00);
    get_rsp("tmo", 8'h00, 2'b10);
    check("tmo_starts", start_cnt - s0, 1);
    check("tmo_latency", rsp_rise - last_start, TMO_RSP_LAT);
    stub_hang = 1'b0;
    wait_idle();

    // Fill FIFO with responses stalled
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("fill_ready", {31'd0, cmd_ready}, 1);
      cmd_valid = 1'b1; cmd_rw = fill_rw[i]; cmd_addr = 7'h01; cmd_wdata = fill_wd[i];
      @(negedge clk);
    end
    cmd_rw = 1'b0; cmd_wdata = 8'h44;
    check("full_count", {29'd0, fifo_count}, 4);
    check("full_ready", {31'd0, cmd_ready}, 0);
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    check("full_count_hold", {29'd0, fifo_count}, 4);
    k = 0;
    while (!rsp_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("stall_rsp_valid", {31'd0, rsp_valid}, 1);
    repeat (4) @(negedge clk);
    check("stall_count", {29'd0, fifo_count}, 4);
    check("stall_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 5; i++) get_rsp("fill", fill_exp[i], 2'b00);
    wait_idle();
    check("drain_count", {29'd0, fifo_count}, 0);

    // Reset during WAIT_DONE aborts silently
    stub_hang = 1'b1;
    push_cmd(1'b0, 7'h01, 8'h77);
    k = 0;
    while (!m_start_txn && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_count", {29'd0, fifo_count}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_data_in", {24'd0, m_data_in}, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid || m_start_txn) bad++;
    end
    check("abort_quiet", bad, 0);
    stub_hang = 1'b0;
    push_cmd(1'b0, 7'h01, 8'h5A);
    get_rsp("post_rst", 8'h00, 2'b00);
    check("post_rst_mem", {24'd0, stub_mem}, 32'h5A);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
